axi4lite_reg_slave: RTL and testbench
=====================================

// Module: axi4lite_reg_slave
// PURPOSE
//   Synthesizable AXI4-Lite responder that terminates the AXI4-Lite master
//   transactions: a bank of NREGS byte-strobed R/W registers at BASE.
//   Accepts AW/W in any order, returns B and R responses with DECERR for
//   unmapped addresses, and exposes register contents and write strobes to user logic.
// PARAMETERS
//   N      4          data bus width in bytes (WDATA/RDATA = 8*N bits)
//   A      32         address width in bits
//   NREGS  16         number of N-byte registers (>=1)
//   BASE   32'h100    byte address of register 0 (N-aligned)
// PORTS
//   Clk      in   1         clock; all logic on rising edge
//   Rst      in   1         synchronous reset, active-high
//   AWADDR   in   A         write address
//   AWPROT   in   3         ignored
//   AWVALID  in   1         write address valid
//   AWREADY  out  1         write address ready
//   WDATA    in   8*N       write data
//   WSTRB    in   N         byte strobes
//   WVALID   in   1         write data valid
//   WREADY   out  1         write data ready
//   BRESP    out  2         2'b00 OKAY / 2'b11 DECERR
//   BVALID   out  1         write response valid
//   BREADY   in   1         write response ready
//   ARADDR   in   A         read address
//   ARPROT   in   3         ignored
//   ARVALID  in   1         read address valid
//   ARREADY  out  1         read address ready
//   RDATA    out  8*N       read data
//   RRESP    out  2         2'b00 OKAY / 2'b11 DECERR
//   RVALID   out  1         read data valid
//   RREADY   in   1         read data ready
//   RegOut   out  NREGS*8N  register contents, reg i at [i*8N +: 8N]
//   WrStb    out  NREGS     1-cycle pulse, bit i = reg i updated this cycle
// BEHAVIOUR
//   Reset (Rst=1 at edge): all outputs 0, registers 0, held AW/W discarded;
//     in-flight B/R dropped; READYs rise first cycle after Rst deasserts.
//   Decode: hit iff BASE <= addr < BASE+NREGS*N; idx=(addr-BASE)/N; low
//     log2(N) addr bits ignored (aligned down). Miss -> DECERR.
//   Write: AW and W channels held independently (aw_full, w_full flags).
//     AWREADY = !aw_full & !BVALID; WREADY = !w_full & !BVALID.
//     Cycle after both held (incl. same-cycle accept of both): for hit, bytes
//     with WSTRB=1 written, WrStb[idx]=1 for that cycle, BRESP=00; miss: no
//     write, WrStb=0, BRESP=11. BVALID=1 same edge; flags cleared.
//     BVALID holds, BRESP stable, until BVALID&BREADY; then BVALID=0.
//     WSTRB=0 on hit: no byte changes, WrStb still pulses, OKAY.
//     Max throughput: one write per 2 cycles with BREADY tied high.
//   Read: ARREADY = !RVALID. On AR handshake at edge t, RDATA/RRESP load at t
//     (visible cycle t+1) with RVALID=1; miss -> RDATA=0, RRESP=11.
//     RDATA/RRESP stable until RVALID&RREADY; then RVALID=0, RDATA keeps value.
//   Simultaneous: read and write channels fully independent; AR accepted in
//     the same cycle a write commits to same reg returns OLD value.
//   VALID deasserted before handshake by master: nothing latched (no X).
// TESTING
//   1 Reset: Rst=1 10 cycles -> all outputs 0; AWREADY/WREADY/ARREADY=1
//     one cycle after Rst=0.
//   2 Write 0x100 data 0x12345678 strb 4'b1011 -> BRESP=00 one cycle after
//     both accepted; reg0=0x12005678; WrStb=16'h0001 for exactly 1 cycle.
//   3 Write 0x12345678 data 0xABCD strb 4'b1111 -> BRESP=11; RegOut unchanged;
//     WrStb stays 0. Read 0x100 -> RDATA=0x12005678, RRESP=00.
//   4 W presented 3 cycles before AW (addr 0x104, 0xDEADBEEF, 4'hF);
//     then BREADY low 5 cycles -> AWREADY/WREADY low while BVALID held;
//     reg1=0xDEADBEEF; read 0x106 -> 0xDEADBEEF (aligned down).
//   5 AR 0x100 same cycle write to 0x100 commits (0x0) -> RDATA=0x12005678;
//     subsequent read -> 0x0. Read 0x140 -> RDATA=0, RRESP=11.
//   6 Rst asserted while BVALID=1 and AW held -> BVALID=0, AW dropped,
//     registers 0; next full write completes normally.

Source files
------------

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NREGS byte-strobed R/W registers mapped at BASE.
// AW and W are captured independently; a write commits on the edge where both are present.
module axi4lite_reg_slave #(
    parameter int          N     = 4,
    parameter int          A     = 32,
    parameter int          NREGS = 16,
    parameter logic [31:0] BASE  = 32'h100
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [A-1:0]            AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [8*N-1:0]          WDATA,
    input  logic [N-1:0]            WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [A-1:0]            ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [8*N-1:0]          RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [NREGS*8*N-1:0]    RegOut,
    output logic [NREGS-1:0]        WrStb
);

    localparam int            DW     = 8 * N;
    localparam int            LN     = (N > 1) ? $clog2(N) : 0;
    localparam int            IW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [A-1:0]  BASE_A = A'(BASE);
    localparam logic [A-1:0]  SPAN   = A'(NREGS * N);
    localparam logic [1:0]    OKAY   = 2'b00;
    localparam logic [1:0]    DECERR = 2'b11;

    // Offset compare also rejects addresses below BASE because the subtraction wraps high.
    function automatic logic addr_hit(input logic [A-1:0] addr);
        return (addr >= BASE_A) && ((addr - BASE_A) < SPAN);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [A-1:0] addr);
        return IW'((addr - BASE_A) >> LN);
    endfunction

    logic [DW-1:0] regs [NREGS];
    logic          out_en;
    logic          aw_full;
    logic          w_full;
    logic [A-1:0]  aw_addr;
    logic [DW-1:0] w_data;
    logic [N-1:0]  w_strb;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [A-1:0]  c_addr;
    logic [DW-1:0] c_data;
    logic [N-1:0]  c_strb;
    logic          c_hit;
    logic [IW-1:0] c_idx;
    logic          r_hit;
    logic [IW-1:0] r_idx;
    logic          unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT};

    // out_en keeps every READY low through reset and for the edge that leaves it.
    assign AWREADY = out_en & ~aw_full & ~BVALID;
    assign WREADY  = out_en & ~w_full & ~BVALID;
    assign ARREADY = out_en & ~RVALID;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign commit = (aw_full | aw_hs) & (w_full | w_hs);

    assign c_addr = aw_full ? aw_addr : AWADDR;
    assign c_data = w_full ? w_data : WDATA;
    assign c_strb = w_full ? w_strb : WSTRB;
    assign c_hit  = addr_hit(c_addr);
    assign c_idx  = addr_idx(c_addr);
    assign r_hit  = addr_hit(ARADDR);
    assign r_idx  = addr_idx(ARADDR);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_en  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            BVALID  <= 1'b0;
            BRESP   <= OKAY;
            WrStb   <= '0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= OKAY;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_en <= 1'b1;
            WrStb  <= '0;

            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end

            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                BVALID  <= 1'b1;
                if (c_hit) begin
                    BRESP        <= OKAY;
                    WrStb[c_idx] <= 1'b1;
                    for (int b = 0; b < N; b++) begin
                        if (c_strb[b]) begin
                            regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
                        end
                    end
                end else begin
                    BRESP <= DECERR;
                end
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_addr <= AWADDR;
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= WDATA;
                    w_strb <= WSTRB;
                end
            end

            // Reads sample regs before this edge's write lands, so a colliding read sees old data.
            if (ar_hs) begin
                RVALID <= 1'b1;
                RDATA  <= r_hit ? regs[r_idx] : '0;
                RRESP  <= r_hit ? OKAY : DECERR;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    always_comb begin
        RegOut = '0;
        for (int i = 0; i < NREGS; i++) begin
            RegOut[i*DW +: DW] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Bench for axi4lite_reg_slave: transaction-level model of the register bank,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_axi4lite_reg_slave;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [31:0]   AWADDR = '0;
    logic [2:0]    AWPROT = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [31:0]   WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [31:0]   ARADDR = '0;
    logic [2:0]    ARPROT = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [511:0]  RegOut;
    logic [15:0]   WrStb;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    axi4lite_reg_slave dut (
        .Clk(Clk), .Rst(Rst),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .RegOut(RegOut), .WrStb(WrStb)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no handshake within cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [16];
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    logic [1:0]  b_q [$];
    logic        r_busy = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_rresp = '0;
    logic [15:0] exp_wrstb = '0;
    logic        rdy_en = 1'b0;
    logic        in_rst = 1'b0;
    logic        started = 1'b0;
    logic        m_ar, m_r, m_aw, m_w, m_b;
    logic [31:0] m_a;
    logic [35:0] m_sw;
    int          m_idx;
    logic [511:0] exp_flat;

    function automatic logic in_map(input logic [31:0] a);
        return (a >= 32'h100) && (a < 32'h140);
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'((a - 32'h100) / 4);
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            foreach (mregs[i]) mregs[i] = '0;
            aw_q.delete();
            w_q.delete();
            b_q.delete();
            r_busy    = 1'b0;
            exp_rdata = '0;
            exp_rresp = '0;
            exp_wrstb = '0;
            rdy_en    = 1'b0;
            in_rst    = 1'b1;
            started   = 1'b1;
        end else begin
            m_ar = ARVALID && rdy_en && !r_busy;
            m_r  = r_busy && RREADY;
            m_aw = AWVALID && rdy_en && aw_q.size() == 0 && b_q.size() == 0;
            m_w  = WVALID && rdy_en && w_q.size() == 0 && b_q.size() == 0;
            m_b  = b_q.size() != 0 && BREADY;
            exp_wrstb = '0;
            if (m_r) r_busy = 1'b0;
            if (m_ar) begin
                if (in_map(ARADDR)) begin
                    exp_rdata = mregs[reg_of(ARADDR)];
                    exp_rresp = 2'b00;
                end else begin
                    exp_rdata = '0;
                    exp_rresp = 2'b11;
                end
                r_busy = 1'b1;
            end
            if (m_b) void'(b_q.pop_front());
            if (m_aw) aw_q.push_back(AWADDR);
            if (m_w) w_q.push_back({WSTRB, WDATA});
            if (aw_q.size() > 0 && w_q.size() > 0) begin
                m_a  = aw_q.pop_front();
                m_sw = w_q.pop_front();
                if (in_map(m_a)) begin
                    m_idx = reg_of(m_a);
                    for (int b = 0; b < 4; b++) begin
                        if (m_sw[32+b]) mregs[m_idx][8*b +: 8] = m_sw[8*b +: 8];
                    end
                    exp_wrstb[m_idx] = 1'b1;
                    b_q.push_back(2'b00);
                end else begin
                    b_q.push_back(2'b11);
                end
            end
            rdy_en = 1'b1;
            in_rst = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            for (int i = 0; i < 16; i++) exp_flat[i*32 +: 32] = mregs[i];
            chk("awready", AWREADY, rdy_en && aw_q.size() == 0 && b_q.size() == 0);
            chk("wready", WREADY, rdy_en && w_q.size() == 0 && b_q.size() == 0);
            chk("arready", ARREADY, rdy_en && !r_busy);
            chk("bvalid", BVALID, b_q.size() != 0);
            if (b_q.size() != 0) chk("bresp", BRESP, b_q[0]);
            chk("rvalid", RVALID, r_busy);
            if (r_busy) chk("rresp", RRESP, exp_rresp);
            chk("rdata", RDATA, exp_rdata);
            chk("wrstb", WrStb, exp_wrstb);
            chk("regout", RegOut, exp_flat);
            if (in_rst) begin
                chk("bresp_rst", BRESP, 2'b00);
                chk("rresp_rst", RRESP, 2'b00);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [31:0] addr, input int dly);
        repeat (dly) @(posedge Clk);
        #1;
        AWADDR  = addr;
        AWVALID = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (AWREADY === 1'b1) begin
                @(posedge Clk);
                #1;
                AWVALID = 1'b0;
                return;
            end
        end
        timeout("aw_handshake");
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        repeat (dly) @(posedge Clk);
        #1;
        WDATA  = data;
        WSTRB  = strb;
        WVALID = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (WREADY === 1'b1) begin
                @(posedge Clk);
                #1;
                WVALID = 1'b0;
                return;
            end
        end
        timeout("w_handshake");
        WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input int dly);
        repeat (dly) @(posedge Clk);
        #1;
        ARADDR  = addr;
        ARVALID = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (ARREADY === 1'b1) begin
                @(posedge Clk);
                #1;
                ARVALID = 1'b0;
                return;
            end
        end
        timeout("ar_handshake");
        ARVALID = 1'b0;
    endtask

    task automatic get_b(input int hold, output logic [1:0] resp);
        resp = 2'bxx;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (BVALID === 1'b1) begin
                resp = BRESP;
                for (int h = 0; h < hold; h++) begin
                    @(negedge Clk);
                    chk("b_hold_awready", AWREADY, 1'b0);
                    chk("b_hold_wready", WREADY, 1'b0);
                end
                @(posedge Clk);
                #1 BREADY = 1'b1;
                @(posedge Clk);
                #1 BREADY = 1'b0;
                return;
            end
        end
        timeout("b_response");
    endtask

    task automatic recv_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
        data = 'x;
        resp = 2'bxx;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (RVALID === 1'b1) begin
                data = RDATA;
                resp = RRESP;
                repeat (hold) @(negedge Clk);
                @(posedge Clk);
                #1 RREADY = 1'b1;
                @(posedge Clk);
                #1 RREADY = 1'b0;
                return;
            end
        end
        timeout("r_response");
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom();
        return 32'hF0 + $urandom_range(0, 'h60);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, wa, wd, ra;
        logic [3:0]  ws;

        // Reset
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        chk("t1_awready_in_rst", AWREADY, 1'b0);
        chk("t1_regout_in_rst", RegOut, '0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("t1_arready_edge0", ARREADY, 1'b0);
        @(negedge Clk);
        chk("t1_awready", AWREADY, 1'b1);
        chk("t1_wready", WREADY, 1'b1);
        chk("t1_arready", ARREADY, 1'b1);
        @(posedge Clk);
        #1;

        // Byte-strobed write to reg0
        fork
            send_aw(32'h100, 0);
            send_w(32'h12345678, 4'b1011, 0);
        join
        @(negedge Clk);
        chk("t2_wrstb", WrStb, 16'h0001);
        chk("t2_reg0", RegOut[31:0], 32'h12005678);
        chk("t2_bvalid", BVALID, 1'b1);
        @(negedge Clk);
        chk("t2_wrstb_off", WrStb, 16'h0000);
        get_b(0, br);
        chk("t2_bresp", br, 2'b00);

        // Unmapped write, then read reg0
        fork
            send_aw(32'h12345678, 0);
            send_w(32'h0000ABCD, 4'hF, 0);
        join
        get_b(0, br);
        chk("t3_bresp", br, 2'b11);
        chk("t3_reg0", RegOut[31:0], 32'h12005678);
        send_ar(32'h100, 0);
        recv_r(0, rd, rr);
        chk("t3_rdata", rd, 32'h12005678);
        chk("t3_rresp", rr, 2'b00);

        // W ahead of AW, slow BREADY, unaligned read
        fork
            send_w(32'hDEADBEEF, 4'hF, 0);
            send_aw(32'h104, 3);
        join
        get_b(5, br);
        chk("t4_bresp", br, 2'b00);
        chk("t4_reg1", RegOut[63:32], 32'hDEADBEEF);
        send_ar(32'h106, 1);
        recv_r(2, rd, rr);
        chk("t4_rdata", rd, 32'hDEADBEEF);
        chk("t4_rresp", rr, 2'b00);

        // Read colliding with a write commit returns old data
        send_w(32'h0, 4'hF, 0);
        fork
            send_aw(32'h100, 0);
            send_ar(32'h100, 0);
        join
        recv_r(0, rd, rr);
        chk("t5_old_rdata", rd, 32'h12005678);
        get_b(0, br);
        chk("t5_bresp", br, 2'b00);
        send_ar(32'h100, 0);
        recv_r(0, rd, rr);
        chk("t5_new_rdata", rd, 32'h0);
        send_ar(32'h140, 0);
        recv_r(0, rd, rr);
        chk("t5_miss_rdata", rd, 32'h0);
        chk("t5_miss_rresp", rr, 2'b11);

        // Randomized concurrent traffic
        for (int i = 0; i < 150; i++) begin
            wa = rand_addr();
            wd = $urandom();
            ws = 4'($urandom_range(0, 15));
            ra = rand_addr();
            fork
                begin
                    fork
                        send_aw(wa, $urandom_range(0, 3));
                        send_w(wd, ws, $urandom_range(0, 3));
                    join
                    get_b($urandom_range(0, 2), br);
                end
                begin
                    send_ar(ra, $urandom_range(0, 3));
                    recv_r($urandom_range(0, 2), rd, rr);
                end
            join
        end

        // Reset with a response outstanding and a stalled AW
        fork
            send_aw(32'h108, 0);
            send_w(32'h55, 4'hF, 0);
        join
        @(posedge Clk);
        #1;
        AWADDR  = 32'h10C;
        AWVALID = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst     = 1'b0;
        AWVALID = 1'b0;
        @(negedge Clk);
        chk("t6_bvalid_dropped", BVALID, 1'b0);
        chk("t6_regs_cleared", RegOut, '0);
        @(posedge Clk);
        #1;
        send_aw(32'h110, 0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        send_w(32'h77, 4'hF, 0);
        repeat (3) @(negedge Clk);
        chk("t6_aw_discarded", BVALID, 1'b0);
        @(posedge Clk);
        #1;
        send_aw(32'h110, 0);
        get_b(0, br);
        chk("t6_bresp", br, 2'b00);
        chk("t6_reg4", RegOut[159:128], 32'h77);

        repeat (3) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
